// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the MIPS instruction memory
//
// Accepts a byte stream (2-byte LE word count, 4*N LE payload bytes, one
// checksum byte) over a valid/ready handshake, writes the assembled 32-bit
// words into instruction memory, and holds the core in reset (cpu_PCinit=1)
// until the 8-bit sum over all bytes, checksum included, is zero.
//
// Ports:
//   clk         rising-edge clock shared with the core
//   PCinit_n    asynchronous active-low reset
//   start       restart pulse, honoured only in DONE or ERR
//   in_valid    in_data holds a byte
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  instruction word to write
//   cpu_PCinit  core reset hold, low only in DONE
//   done        image loaded and checksum good
//   err         load aborted (oversize count or bad checksum)
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              PCinit_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_PCinit,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_CNT0  = 3'd0;
  localparam logic [2:0] S_CNT1  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Largest legal word count is the full memory capacity, so compare in 17 bits.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  logic [2:0]      state;
  logic [15:0]     count;
  logic [7:0]      sum;
  logic [1:0]      byte_cnt;
  // One extra bit so the index can reach 2^ADDR_W when memory is filled.
  logic [ADDR_W:0] word_idx;
  logic [31:0]     asm_word;

  logic            accept;
  logic [7:0]      sum_next;
  logic [15:0]     n_full;
  logic [ADDR_W:0] idx_next;
  logic [31:0]     word_next;

  // Decoded from registered state only: no path from in_valid.
  assign in_ready  = (state == S_CNT0) || (state == S_CNT1) ||
                     (state == S_DATA) || (state == S_CSUM);
  assign accept    = in_valid & in_ready;
  assign sum_next  = sum + in_data;
  assign n_full    = {in_data, count[7:0]};
  assign idx_next  = word_idx + {{ADDR_W{1'b0}}, 1'b1};
  // Shift right so the first byte of a word ends up in bits 7:0.
  assign word_next = {in_data, asm_word[31:8]};

  always_ff @(posedge clk or negedge PCinit_n) begin
    if (!PCinit_n) begin
      state      <= S_CNT0;
      count      <= '0;
      sum        <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      asm_word   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_PCinit <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_CNT0: begin
          if (accept) begin
            count[7:0] <= in_data;
            sum        <= sum_next;
            state      <= S_CNT1;
          end
        end
        S_CNT1: begin
          if (accept) begin
            count[15:8] <= in_data;
            sum         <= sum_next;
            if ({1'b0, n_full} > MAX_WORDS) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else if (n_full == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            sum      <= sum_next;
            asm_word <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= S_WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= word_next;
            end
          end
        end
        S_WRITE: begin
          imem_we  <= 1'b0;
          word_idx <= idx_next;
          if (17'(idx_next) == {1'b0, count}) state <= S_CSUM;
          else                                 state <= S_DATA;
        end
        S_CSUM: begin
          if (accept) begin
            sum <= sum_next;
            if (sum_next == 8'd0) begin
              state      <= S_DONE;
              done       <= 1'b1;
              cpu_PCinit <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_CNT0;
            done       <= 1'b0;
            err        <= 1'b0;
            sum        <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            cpu_PCinit <= 1'b1;
          end
        end
        default: state <= S_CNT0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              PCinit_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_PCinit;
  logic              done;
  logic              err;

  int total = 0;
  int bad = 0;
  int ready_viol = 0;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic [7:0]        stream[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .PCinit_n  (PCinit_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_PCinit(cpu_PCinit),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
      if (in_ready) ready_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic load(input int gap_max);
    foreach (stream[i]) begin
      send(stream[i]);
      repeat ($urandom_range(0, gap_max)) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() >= 2) begin
      chk({tag, "_a0"}, 32'(wq_addr[0]), 32'd0);
      chk({tag, "_d0"}, wq_data[0], 32'h20080005);
      chk({tag, "_a1"}, 32'(wq_addr[1]), 32'd1);
      chk({tag, "_d1"}, wq_data[1], 32'h2009000A);
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pcinit"}, 32'(cpu_PCinit), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_pcinit", 32'(cpu_PCinit), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    PCinit_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Good load N=2, cycle-level latency checks
    stream = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
               8'h0A, 8'h00, 8'h09, 8'h20, 8'h9E};
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 6; i++) send(stream[i]);
    chk("g_we_latency", 32'(imem_we), 32'd1);
    chk("g_we_addr", 32'(imem_addr), 32'd0);
    chk("g_we_data", imem_wdata, 32'h20080005);
    chk("g_write_ready", 32'(in_ready), 32'd0);
    for (int i = 6; i < 10; i++) send(stream[i]);
    chk("g_hold_pcinit", 32'(cpu_PCinit), 32'd1);
    chk("g_hold_done", 32'(done), 32'd0);
    send(stream[10]);
    check_done("g");
    @(negedge clk);
    check_two_writes("g");

    // Bad checksum
    pulse_start();
    chk("s_err_clr", 32'(err), 32'd0);
    chk("s_pcinit", 32'(cpu_PCinit), 32'd1);
    chk("s_done_clr", 32'(done), 32'd0);
    wq_addr.delete(); wq_data.delete();
    stream[10] = 8'h9F;
    load(0);
    chk("b_err", 32'(err), 32'd1);
    chk("b_pcinit", 32'(cpu_PCinit), 32'd1);
    chk("b_done", 32'(done), 32'd0);
    check_two_writes("b");

    // Good load with random gaps between bytes
    pulse_start();
    wq_addr.delete(); wq_data.delete();
    ready_viol = 0;
    stream[10] = 8'h9E;
    load(3);
    check_done("r");
    @(negedge clk);
    check_two_writes("r");
    chk("r_ready_in_write", 32'(ready_viol), 32'd0);

    // Empty image
    pulse_start();
    wq_addr.delete(); wq_data.delete();
    stream = '{8'h00, 8'h00};
    load(0);
    chk("e_not_yet", 32'(done), 32'd0);
    send(8'h00);
    check_done("e");
    chk("e_nwr", 32'(wq_addr.size()), 32'd0);

    // Oversize count N=1025
    pulse_start();
    wq_addr.delete(); wq_data.delete();
    stream = '{8'h01, 8'h04};
    load(0);
    chk("o_err", 32'(err), 32'd1);
    chk("o_ready", 32'(in_ready), 32'd0);
    chk("o_pcinit", 32'(cpu_PCinit), 32'd1);
    repeat (3) @(negedge clk);
    chk("o_nwr", 32'(wq_addr.size()), 32'd0);
    pulse_start();
    chk("o_restart_err", 32'(err), 32'd0);
    chk("o_restart_ready", 32'(in_ready), 32'd1);
    stream = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
               8'h0A, 8'h00, 8'h09, 8'h20, 8'h9E};
    load(0);
    check_done("o2");
    @(negedge clk);
    check_two_writes("o2");

    // Asynchronous reset mid-load, then reload from address 0
    pulse_start();
    for (int i = 0; i < 5; i++) send(stream[i]);
    #2;
    PCinit_n = 1'b0;
    #1;
    chk("a_we", 32'(imem_we), 32'd0);
    chk("a_addr", 32'(imem_addr), 32'd0);
    chk("a_wdata", imem_wdata, 32'd0);
    chk("a_pcinit", 32'(cpu_PCinit), 32'd1);
    chk("a_done", 32'(done), 32'd0);
    chk("a_err", 32'(err), 32'd0);
    @(negedge clk);
    PCinit_n = 1'b1;
    @(negedge clk);
    chk("a_ready", 32'(in_ready), 32'd1);
    wq_addr.delete(); wq_data.delete();
    load(0);
    check_done("a2");
    @(negedge clk);
    check_two_writes("a2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into instruction memory. It holds the core's `PCinit` asserted for the whole load and releases it only after the stream's checksum verifies. The core therefore always starts fetching at address 0 from a complete, checked image.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1: rising-edge clock, shared with the core.
- `PCinit_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: pulse that restarts loading; honoured only in DONE or ERR.
- `in_valid`  in  1: `in_data` holds a byte.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader can accept a byte this cycle.
- `imem_we`  out  1: one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W: word address of the write.
- `imem_wdata`  out  32: instruction word to write.
- `cpu_PCinit`  out  1: drives the core's `PCinit`; 1 holds the core in reset.
- `done`  out  1: image loaded and checksum good.
- `err`  out  1: load aborted (oversize count or bad checksum).

## Operation
- Stream format:
  - 2-byte word count N, little-endian.
  - 4·N payload bytes; each word is little-endian, so the first byte goes to bits 7:0.
  - 1 checksum byte, chosen so that the 8-bit sum of all bytes, including the checksum, is 0x00.
- A byte is accepted on a rising edge with `in_valid & in_ready`.
- States:
  - CNT0: accept low count byte → CNT1.
  - CNT1: accept high count byte.
    - N > 2^ADDR_W → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: accept bytes into a 32-bit shift/assembly register using a 2-bit byte counter. The 4th accepted byte → WRITE.
  - WRITE: `imem_we`=1 for exactly this cycle, with `imem_addr`=word index and `imem_wdata`=assembled word.
    - Word index then increments.
    - Index == N → CSUM; otherwise → DATA.
  - CSUM: accept checksum byte. Running sum plus this byte == 0x00 → DONE; otherwise → ERR.
  - DONE: `done`=1 and `cpu_PCinit`=0. `start` → CNT0.
  - ERR: `err`=1 and `cpu_PCinit`=1. `start` → CNT0.
- Running sum: 8-bit wrap-around accumulator over every accepted byte.
- On entering CNT0 via `start`, clear `done`, `err`, the sum, the byte counter and the word index, and set `cpu_PCinit`=1.
- `in_ready` = 1 in CNT0, CNT1, DATA and CSUM; 0 in WRITE, DONE and ERR.
- `cpu_PCinit` = 1 in every state except DONE.
- `start` is ignored in CNT0, CNT1, DATA, WRITE and CSUM.
- Words already written before an ERR remain in memory; the core stays held.
- `in_data` is ignored whenever `in_valid & in_ready` is low.

## Timing
- Reset (`PCinit_n`=0, asynchronous):
  - state = CNT0.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_PCinit`=1, `done`=0, `err`=0.
  - `in_ready`=1 once `PCinit_n` rises.
- Reset mid-load aborts immediately; partial memory contents are not erased.
- `in_ready` is decoded from the registered state, with no combinational path from `in_valid`.
- `imem_we`, `imem_addr`, `imem_wdata`, `done`, `err` and `cpu_PCinit` are registered.
- Write latency: `imem_we` is high in the cycle after the edge that accepted a word's 4th byte.
- With `in_valid` held high, the throughput is one word per 5 cycles.
- Release: `cpu_PCinit` falls and `done` rises in the cycle after the edge that accepts a good checksum byte.
- Oversize count: `err` rises in the cycle after the edge accepting the high count byte. No `imem_we` follows.
- `start` takes effect on the next edge: the following cycle is CNT0.

## Test plan
- Good load of N=2 with words 0x20080005 and 0x2009000A. Stream 02 00 05 00 08 20 0A 00 09 20 9E →
  - exactly two writes: addr 0 = 0x20080005, addr 1 = 0x2009000A;
  - then `done`=1, `cpu_PCinit`=0, `err`=0.
- Same stream with last byte 0x9F → both writes occur, then `err`=1, `cpu_PCinit` stays 1, `done`=0.
- Good load with `in_valid` randomly deasserted between bytes → identical writes and result. `in_ready` is 0 in each WRITE cycle and no byte is lost.
- Empty image, stream 00 00 00 → no `imem_we`; `done`=1 and `cpu_PCinit`=0 one cycle after the third byte.
- With ADDR_W=10, count bytes 01 04 (N=1025) → `err`=1, `in_ready`=0, no writes. Then pulse `start` → CNT0 with `err`=0, and a subsequent good stream completes with `done`=1.
- Assert `PCinit_n`=0 after 3 payload bytes → all outputs return to reset values asynchronously. A full stream sent after release loads correctly from addr 0.
